booth_multiplier: RTL and testbench
===================================

BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

Interface
REQ-001 The block SHALL have port `clock`, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port `ctrl_MULT`, input, 1 bit: start pulse; operands are sampled on the edge where it is high.
REQ-004 The block SHALL have port `data_operandA`, input, 32 bits: signed two's-complement multiplicand.
REQ-005 The block SHALL have port `data_operandB`, input, 32 bits: signed two's-complement multiplier.
REQ-006 The block SHALL have port `product`, output, 64 bits: signed full product A*B.
REQ-007 The block SHALL have port `data_resultRDY`, output, 1 bit: one-cycle pulse marking `product` valid.
REQ-008 The block SHALL have port `data_exception`, output, 1 bit: the product does not fit in signed 32 bits.
REQ-009 Clock and reset SHALL be named `clock` and `reset`; reset SHALL be synchronous and active-high.

Function
REQ-010 The block SHALL implement radix-4 Booth multiplication.
  - Recode one 3-bit window of B per cycle.
  - Add 0, ±A or ±2A (65-bit sign-extended) to the accumulator.
  - Arithmetic-shift right by 2.
REQ-011 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-012 In IDLE with `ctrl_MULT`=1, the block SHALL latch A and B, clear the accumulator, set iteration counter=0 and go to RUN.
REQ-013 In RUN, the block SHALL perform one Booth step per cycle and increment the counter.
  - After step 16 (counter=15 at the edge), go to DONE.
REQ-014 `data_resultRDY` SHALL be 1 exactly while in DONE.
  - This is exactly 16 rising edges after the edge that sampled `ctrl_MULT`.
  - DONE SHALL return to IDLE on the next edge.
REQ-015 `product` SHALL update only on entry to DONE and SHALL hold that value until the next DONE or reset.
REQ-016 `ctrl_MULT`=1 while in RUN SHALL abort the current operation and restart with the new operands; no `data_resultRDY` SHALL be issued for the aborted operation.
REQ-017 `ctrl_MULT`=1 while in DONE SHALL still pulse `data_resultRDY` for the completed result and SHALL enter RUN with the new operands, skipping IDLE.
REQ-018 `data_exception` SHALL be computed from the final product: 1 iff product[63:31] is neither all-0 nor all-1.
  - It is valid and held with `product`.
REQ-019 The operand value 0x80000000 (most negative) SHALL be handled correctly in either operand position; no special casing is permitted to alter the result.

Reset
REQ-020 When `reset`=1 at a rising edge, the block SHALL go to IDLE and set counter=0, `product`=0, `data_resultRDY`=0 and `data_exception`=0.
REQ-021 Reset SHALL take priority over `ctrl_MULT`.
REQ-022 Reset mid-RUN SHALL discard the operation with no `data_resultRDY` pulse.

Configuration
REQ-023 With macro `BOOTH_MULT_EXCEPTION_EN` defined, the block SHALL drive `data_exception` per REQ-018.
REQ-024 Without `BOOTH_MULT_EXCEPTION_EN`, `data_exception` SHALL be tied to 0, its register SHALL be omitted, and `product` and latency SHALL be unchanged.

Structure
REQ-025 Shared package `multdiv_pkg` SHALL hold:
  - the state enum (IDLE, RUN, DONE);
  - MULT_ITERATIONS=16;
  - OPERAND_W=32 and PRODUCT_W=64;
  - the Booth select encoding (ZERO, PLUS_A, PLUS_2A, MINUS_A, MINUS_2A).
REQ-026 Sub-module `booth_recoder` SHALL be used: combinational mapping of a 3-bit window to a Booth select code; instantiated once.

Verification
REQ-027 A=3, B=28, 1-cycle `ctrl_MULT` SHALL give `data_resultRDY` exactly 16 edges later, `product`=84, `data_exception`=0, then `data_resultRDY`=0 on the next cycle.
REQ-028 A=-7, B=6 SHALL give `product`=0xFFFFFFFFFFFFFFD6 (-42) and `data_exception`=0.
REQ-029 A=0x7FFFFFFF, B=2 SHALL give `product`=0x00000000FFFFFFFE and `data_exception`=1 with the macro, 0 without.
REQ-030 A=0x80000000, B=0xFFFFFFFF SHALL give `product`=0x0000000080000000 and `data_exception`=1.
REQ-031 Start A=5, B=5; at edge 8 re-pulse `ctrl_MULT` with A=4, B=-3; the bench SHALL see exactly one `data_resultRDY`, 16 edges after the second start, with `product`=-12.
REQ-032 Start A=9, B=9; assert `reset` at edge 10; the bench SHALL see no `data_resultRDY`, and `product`=0 and FSM=IDLE afterwards.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide unit: FSM states,
// operand/product widths and the radix-4 Booth select encoding.
package multdiv_pkg;

    localparam int OPERAND_W       = 32;
    localparam int PRODUCT_W       = 64;
    localparam int MULT_ITERATIONS = 16;

    // High accumulator half must hold +/-2A plus a carried partial sum
    localparam int ADDEND_W = OPERAND_W + 2;
    localparam int ACC_W    = ADDEND_W + OPERAND_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } multState_e;

    typedef enum logic [2:0] {
        ZERO,
        PLUS_A,
        PLUS_2A,
        MINUS_A,
        MINUS_2A
    } boothSel_e;

    // True when a full product cannot be represented as a signed 32-bit word
    function automatic logic overflowsWord(input logic [PRODUCT_W-1:0] p);
        return !((&p[PRODUCT_W-1:OPERAND_W-1]) || !(|p[PRODUCT_W-1:OPERAND_W-1]));
    endfunction

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window {b[i+1], b[i], b[i-1]}
// to the multiple of the multiplicand that must be added this step.
module booth_recoder
    import multdiv_pkg::*;
(
    input  logic [2:0] window_i,
    output boothSel_e  sel_o
);

    always_comb begin
        sel_o = ZERO;
        case (window_i)
            3'b001, 3'b010: sel_o = PLUS_A;
            3'b011:         sel_o = PLUS_2A;
            3'b100:         sel_o = MINUS_2A;
            3'b101, 3'b110: sel_o = MINUS_A;
            default:        sel_o = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed 32x32 radix-4 Booth multiplier, one window per cycle.
// Define BOOTH_MULT_EXCEPTION_EN to drive data_exception; otherwise it is tied low.
module booth_multiplier
    import multdiv_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ctrl_MULT,
    input  logic [OPERAND_W-1:0] data_operandA,
    input  logic [OPERAND_W-1:0] data_operandB,
    output logic [PRODUCT_W-1:0] product,
    output logic                 data_resultRDY,
    output logic                 data_exception
);

    localparam logic [3:0] LAST_STEP = 4'(MULT_ITERATIONS - 1);

    multState_e           state_q;
    logic [OPERAND_W-1:0] mcand_q;
    logic [ACC_W-1:0]     acc_q;
    logic [ACC_W-1:0]     acc_d;
    logic [3:0]           count_q;
    logic [PRODUCT_W-1:0] product_q;
    logic [PRODUCT_W-1:0] product_d;
    logic                 rdy_q;

    boothSel_e            sel;
    logic [ADDEND_W-1:0]  mcandExt;
    logic [ADDEND_W-1:0]  addend;
    logic [ADDEND_W-1:0]  sumHigh;

    // acc_q = {partial product high half, multiplier bits, implicit b[-1]}
    booth_recoder uRecoder (
        .window_i (acc_q[2:0]),
        .sel_o    (sel)
    );

    always_comb begin
        mcandExt = {{2{mcand_q[OPERAND_W-1]}}, mcand_q};
        addend   = '0;
        case (sel)
            PLUS_A:   addend = mcandExt;
            PLUS_2A:  addend = mcandExt << 1;
            MINUS_A:  addend = -mcandExt;
            MINUS_2A: addend = -(mcandExt << 1);
            default:  addend = '0;
        endcase
        sumHigh   = acc_q[ACC_W-1 -: ADDEND_W] + addend;
        acc_d     = {{2{sumHigh[ADDEND_W-1]}}, sumHigh, acc_q[OPERAND_W:2]};
        product_d = acc_d[PRODUCT_W:1];
    end

`ifdef BOOTH_MULT_EXCEPTION_EN
    logic exception_q;
`endif

    // A start pulse wins in every state, which gives both abort-and-restart
    // from RUN and back-to-back restart straight out of DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            product_q   <= '0;
            rdy_q       <= 1'b0;
`ifdef BOOTH_MULT_EXCEPTION_EN
            exception_q <= 1'b0;
`endif
        end else begin
            rdy_q <= 1'b0;
            if (ctrl_MULT) begin
                mcand_q <= data_operandA;
                acc_q   <= {{ADDEND_W{1'b0}}, data_operandB, 1'b0};
                count_q <= '0;
                state_q <= RUN;
            end else begin
                case (state_q)
                    RUN: begin
                        acc_q   <= acc_d;
                        count_q <= count_q + 4'd1;
                        if (count_q == LAST_STEP) begin
                            state_q     <= DONE;
                            product_q   <= product_d;
                            rdy_q       <= 1'b1;
`ifdef BOOTH_MULT_EXCEPTION_EN
                            exception_q <= overflowsWord(product_d);
`endif
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign product        = product_q;
    assign data_resultRDY = rdy_q;

`ifdef BOOTH_MULT_EXCEPTION_EN
    assign data_exception = exception_q;
`else
    assign data_exception = 1'b0;
`endif

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed corner cases, abort,
// back-to-back and reset scenarios, plus randomized operands against a signed model.
module tb_booth_multiplier;
    import multdiv_pkg::*;

`ifdef BOOTH_MULT_EXCEPTION_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    localparam longint MAX32 = 64'sd2147483647;
    localparam longint MIN32 = -64'sd2147483648;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [63:0] product;
    logic        data_resultRDY;
    logic        data_exception;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] lastProduct;

    booth_multiplier dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (opA),
        .data_operandB  (opB),
        .product        (product),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    function automatic logic refException(input logic [63:0] p);
        longint sp;
        sp = longint'(p);
        return EXC_EN && ((sp > MAX32) || (sp < MIN32));
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        opA       = a;
        opB       = b;
        ctrl_MULT = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        opA       = $urandom;
        opB       = $urandom;
    endtask

    // Waits the 16 edges after a start; product must hold its old value meanwhile
    task automatic waitResult(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] expected;
        int          early;
        expected = refProduct(a, b);
        early    = 0;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) early++;
            if (i == 8) checkOutput({tag, "/hold"}, product, lastProduct);
        end
        @(posedge clock);
        #1;
        checkOutput({tag, "/early"}, 64'(early), 64'd0);
        checkOutput({tag, "/rdy"}, 64'(data_resultRDY), 64'd1);
        checkOutput({tag, "/prod"}, product, expected);
        checkOutput({tag, "/exc"}, 64'(data_exception), 64'(refException(expected)));
        lastProduct = expected;
    endtask

    task automatic runAndCheck(input logic [31:0] a, input logic [31:0] b, input string tag);
        applyStimulus(a, b);
        waitResult(a, b, tag);
        @(posedge clock);
        #1;
        checkOutput({tag, "/rdyDrop"}, 64'(data_resultRDY), 64'd0);
        checkOutput({tag, "/keep"}, product, lastProduct);
    endtask

    initial begin
        int          pulses;
        int          firstAt;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] edgeVals [5];

        edgeVals[0] = 32'h0000_0000;
        edgeVals[1] = 32'h0000_0001;
        edgeVals[2] = 32'hFFFF_FFFF;
        edgeVals[3] = 32'h7FFF_FFFF;
        edgeVals[4] = 32'h8000_0000;

        reset       = 1'b1;
        ctrl_MULT   = 1'b1;
        opA         = 32'd7;
        opB         = 32'd7;
        lastProduct = '0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset/prod", product, 64'd0);
        checkOutput("reset/rdy", 64'(data_resultRDY), 64'd0);
        checkOutput("reset/exc", 64'(data_exception), 64'd0);
        checkOutput("reset/state", 64'(dut.state_q), 64'(IDLE));
        @(negedge clock);
        reset     = 1'b0;
        ctrl_MULT = 1'b0;

        runAndCheck(32'd3, 32'd28, "a3b28");
        runAndCheck(-32'sd7, 32'd6, "aM7b6");
        runAndCheck(32'h7FFF_FFFF, 32'd2, "maxTimes2");
        runAndCheck(32'h8000_0000, 32'hFFFF_FFFF, "minTimesM1");
        runAndCheck(32'h8000_0000, 32'h8000_0000, "minTimesMin");
        runAndCheck(32'h7FFF_FFFF, 32'h8000_0000, "maxTimesMin");
        runAndCheck(32'd0, 32'h8000_0000, "zeroTimesMin");

        for (int n = 0; n < 12; n++) begin
            case ($urandom_range(0, 2))
                0: begin
                    ra = $urandom;
                    rb = $urandom;
                end
                1: begin
                    ra = 32'($urandom_range(0, 4000)) - 32'd2000;
                    rb = 32'($urandom_range(0, 4000)) - 32'd2000;
                end
                default: begin
                    ra = edgeVals[$urandom_range(0, 4)];
                    rb = $urandom;
                end
            endcase
            runAndCheck(ra, rb, $sformatf("rand%0d", n));
        end

        // Restart mid-run: only the second operation may complete
        applyStimulus(32'd5, 32'd5);
        pulses = 0;
        repeat (7) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        applyStimulus(32'd4, -32'sd3);
        firstAt = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                pulses++;
                if (firstAt < 0) firstAt = i;
            end
            if (i == 8) checkOutput("abort/hold", product, lastProduct);
        end
        checkOutput("abort/pulses", 64'(pulses), 64'd1);
        checkOutput("abort/latency", 64'(firstAt), 64'd16);
        checkOutput("abort/prod", product, 64'hFFFF_FFFF_FFFF_FFF4);
        lastProduct = 64'hFFFF_FFFF_FFFF_FFF4;

        // Start arriving in DONE: result still pulses, next op skips IDLE
        applyStimulus(32'd1234, -32'sd99);
        waitResult(32'd1234, -32'sd99, "ovl1");
        applyStimulus(32'hDEAD_BEEF, 32'h0BAD_F00D);
        waitResult(32'hDEAD_BEEF, 32'h0BAD_F00D, "ovl2");
        @(posedge clock);
        #1;
        checkOutput("ovl2/rdyDrop", 64'(data_resultRDY), 64'd0);

        // Reset mid-run, colliding with a start pulse that must lose
        applyStimulus(32'd9, 32'd9);
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset     = 1'b1;
        ctrl_MULT = 1'b1;
        opA       = 32'd100;
        opB       = 32'd100;
        @(negedge clock);
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        pulses    = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        checkOutput("rstMid/pulses", 64'(pulses), 64'd0);
        checkOutput("rstMid/prod", product, 64'd0);
        checkOutput("rstMid/exc", 64'(data_exception), 64'd0);
        checkOutput("rstMid/state", 64'(dut.state_q), 64'(IDLE));
        lastProduct = '0;

        runAndCheck(32'd3, 32'd28, "afterReset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
